fifo_wr_arb: RTL
================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8: FIFO entries; count width is clog2(DEPTH)+1.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have ports req0/req1, input, 1 each: write request from producer 0/1, held until granted.
REQ-006 The block SHALL have ports data0/data1, input, WIDTH each: producer write data, stable while req high.
REQ-007 The block SHALL have ports gnt0/gnt1, output, 1 each: one-cycle write grant to producer 0/1.
REQ-008 The block SHALL have port rd_req, input, 1: consumer read request, sampled each edge and not queued.
REQ-009 The block SHALL have port rd_valid, output, 1: one-cycle strobe marking rd_data as valid.
REQ-010 The block SHALL have port rd_data, output, WIDTH: byte read from the FIFO, held until the next rd_valid.
REQ-011 The block SHALL have ports fifo_we and fifo_re, output, 1 each: write and read strobes to the FIFO memory.
REQ-012 The block SHALL have port fifo_wdata, output, WIDTH: write data to the FIFO memory.
REQ-013 The block SHALL have port fifo_rdata, input, WIDTH: FIFO memory read data, valid one cycle after fifo_re.
REQ-014 The block SHALL have ports full, empty, count, output, 1/1/clog2(DEPTH)+1: occupancy status.

Function
REQ-015 Eligibility SHALL be req_x high, gnt_x low in the current cycle (no back-to-back grant to the same producer), and count < DEPTH.
REQ-016 At each edge with at least one eligible producer, exactly one of gnt0/gnt1 SHALL go high for one cycle, together with fifo_we=1 and fifo_wdata=data of the winner.
REQ-017 When both producers are eligible, the winner SHALL be the producer not granted most recently (round-robin pointer), unless ARB_FIXED_PRIO_EN is defined.
REQ-018 When no producer is eligible, gnt0, gnt1 and fifo_we SHALL be 0 at the next edge; a held request to a full FIFO SHALL wait without loss.
REQ-019 A read freed at the same edge SHALL NOT make a full FIFO eligible for a write at that edge.
REQ-020 The read FSM SHALL have states R_IDLE, R_ISSUE and R_DATA. R_IDLE goes to R_ISSUE on rd_req with count > 0. R_ISSUE drives fifo_re=1 for one cycle and then goes to R_DATA. R_DATA latches fifo_rdata into rd_data, drives rd_valid=1 for one cycle, and returns to R_IDLE.
REQ-021 rd_req SHALL be ignored while empty, while in R_ISSUE, and while in R_DATA; rd_valid SHALL stay 0 in those cases.
REQ-022 Read latency SHALL be fixed: rd_req sampled at edge N gives fifo_re high after edge N+1 and rd_valid high after edge N+2.
REQ-023 count SHALL increment at the edge asserting fifo_we, decrement at the edge asserting fifo_re, and stay unchanged when both occur.
REQ-024 count SHALL never exceed DEPTH nor go below 0.
REQ-025 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both registered with count.

Reset
REQ-026 While rst_n is low, gnt0, gnt1, fifo_we, fifo_re, rd_valid, fifo_wdata, rd_data and count SHALL be 0, full SHALL be 0 and empty SHALL be 1.
REQ-027 While rst_n is low, the round-robin pointer SHALL indicate producer 1 was last granted, and the read FSM SHALL be in R_IDLE.
REQ-028 Reset asserted mid-read SHALL discard the in-flight read with no rd_valid; the FIFO memory SHALL share rst_n so its pointers match count=0.
REQ-029 The first edge after rst_n rises SHALL perform normal arbitration.

Configuration
REQ-030 With ARB_FIXED_PRIO_EN defined, producer 0 SHALL win whenever both are eligible.
REQ-031 Without ARB_FIXED_PRIO_EN, round-robin per REQ-017 SHALL apply. The exclusion in REQ-015 SHALL apply in both modes.

Verification
REQ-032 Scenario: req0 alone with data0=8'h02, 8'h04, 8'h08 in sequence -> gnt0 high every other cycle, fifo_wdata matches each value, count ends at 3.
REQ-033 Scenario: req0 and req1 held together after reset with data0=8'hAA, data1=8'h55 -> grants alternate starting with gnt0; with ARB_FIXED_PRIO_EN the order is identical because of REQ-015.
REQ-034 Scenario: write 8 bytes 8'h02..8'hff, then hold req1 -> full=1, count=8, no gnt1 until a read completes; gnt1 follows the edge after count drops to 7.
REQ-035 Scenario: 8 bytes stored, rd_req held high -> rd_valid every third cycle, rd_data in write order, empty=1 after the 8th read, then no further rd_valid.
REQ-036 Scenario: count=4 with a write and a read issued at the same edge -> count stays 4.
REQ-037 Scenario: rst_n pulsed low in R_ISSUE -> no rd_valid, count=0, empty=1; rd_req while empty -> no fifo_re.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Handshake bundle for fifo_wr_arb: two write producers, one reader, and the FIFO memory strobes.
interface fifo_wr_arb_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1;
  logic             rd_req, rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             fifo_we, fifo_re;
  logic [WIDTH-1:0] fifo_wdata, fifo_rdata;
  logic             full, empty;
  logic [CW-1:0]    count;

  modport slave (
    input  req0, req1, data0, data1, rd_req, fifo_rdata,
    output gnt0, gnt1, rd_valid, rd_data, fifo_we, fifo_re, fifo_wdata, full, empty, count
  );

  modport master (
    output req0, req1, data0, data1, rd_req, fifo_rdata,
    input  gnt0, gnt1, rd_valid, rd_data, fifo_we, fifo_re, fifo_wdata, full, empty, count
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Two-producer write arbiter with occupancy tracking and a fixed-latency read sequencer.
// Define ARB_FIXED_PRIO_EN to give producer 0 priority instead of round-robin.
module fifo_wr_arb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_wr_arb_if.slave  bus
);
  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} rd_state_t;

  rd_state_t        state_q, state_d;
  logic             gnt0_q, gnt1_q, we_q, re_q, rvalid_q, last_q;
  logic             gnt0_d, gnt1_d, we_d, re_d, rvalid_d, last_d;
  logic [WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             elig0, elig1, pick1;

  // Eligibility uses the registered count, so a read retiring at this edge cannot unblock a full FIFO.
  always_comb begin
    elig0 = bus.req0 && !gnt0_q && (count_q < DEPTH_C);
    elig1 = bus.req1 && !gnt1_q && (count_q < DEPTH_C);
`ifdef ARB_FIXED_PRIO_EN
    pick1 = elig1 && !elig0;
`else
    pick1 = elig1 && (!elig0 || !last_q);
`endif
    gnt1_d  = pick1;
    gnt0_d  = elig0 && !pick1;
    we_d    = elig0 || elig1;
    wdata_d = wdata_q;
    last_d  = last_q;
    if (gnt1_d) begin
      wdata_d = bus.data1;
      last_d  = 1'b1;
    end else if (gnt0_d) begin
      wdata_d = bus.data0;
      last_d  = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    re_d     = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      R_IDLE:  if (bus.rd_req && (count_q != '0)) state_d = R_ISSUE;
      R_ISSUE: begin
        re_d    = 1'b1;
        state_d = R_DATA;
      end
      R_DATA: begin
        rdata_d  = bus.fifo_rdata;
        rvalid_d = 1'b1;
        state_d  = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (we_d && !re_d)      count_d = count_q + CW'(1);
    else if (re_d && !we_d) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= R_IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      rvalid_q <= 1'b0;
      last_q   <= 1'b1;
      wdata_q  <= '0;
      rdata_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      we_q     <= we_d;
      re_q     <= re_d;
      rvalid_q <= rvalid_d;
      last_q   <= last_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.fifo_we    = we_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.fifo_re    = re_q;
  assign bus.rd_valid   = rvalid_q;
  assign bus.rd_data    = rdata_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
endmodule
